// File: rtl/ripple_counter_ctrl_if.sv
// ripple_counter_ctrl_if: host-side request/result bus of the ripple counter measurement sequencer
interface ripple_counter_ctrl_if #(
    parameter int CNT_W    = 65,
    parameter int WINDOW_W = 16
);
    logic                start;
    logic                abort;
    logic [WINDOW_W-1:0] window;
    logic                busy;
    logic                res_valid;
    logic                res_ready;
    logic [CNT_W-1:0]    res_data;
    logic                res_err;
    modport master (
        output start, abort, window, res_ready,
        input  busy, res_valid, res_data, res_err
    );
    modport slave (
        input  start, abort, window, res_ready,
        output busy, res_valid, res_data, res_err
    );
endinterface

// File: rtl/ripple_counter_ctrl.sv
// ripple_counter_ctrl: clear/gate/settle/sample sequencer for a ripple counter, result on a valid/ready port
// Optional double-sampling with retries is enabled by defining RIPPLE_CTRL_DBLSAMPLE_EN.
module ripple_counter_ctrl #(
    parameter int CNT_W         = 65,
    parameter int WINDOW_W      = 16,
    parameter int CLEAR_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    ripple_counter_ctrl_if.slave bus,
    input  logic [CNT_W-1:0]     ctr_q,
    output logic                 ctr_clr,
    output logic                 ctr_gate
);
    localparam int MAX_CYC = CLEAR_CYCLES > SETTLE_CYCLES ? CLEAR_CYCLES : SETTLE_CYCLES;
    localparam int CYC_W   = $clog2(MAX_CYC + 1);
    localparam int PH_W    = WINDOW_W > CYC_W ? WINDOW_W : CYC_W;
`ifdef RIPPLE_CTRL_DBLSAMPLE_EN
    localparam int SAMP_LD = 1;
`else
    localparam int SAMP_LD = 0;
`endif
    localparam logic [PH_W-1:0] CLR_LD = PH_W'(CLEAR_CYCLES - 1);
    localparam logic [PH_W-1:0] SET_LD = PH_W'(SETTLE_CYCLES - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLEAR  = 3'd1;
    localparam logic [2:0] GATE   = 3'd2;
    localparam logic [2:0] SETTLE = 3'd3;
    localparam logic [2:0] SAMPLE = 3'd4;
    localparam logic [2:0] RESULT = 3'd5;

    logic [2:0]          state, nstate;
    logic [PH_W-1:0]     cnt, ncnt;
    logic [WINDOW_W-1:0] win, nwin;
    logic [CNT_W-1:0]    data, ndata;
    logic                busy_q, valid_q, done;
`ifdef RIPPLE_CTRL_DBLSAMPLE_EN
    logic                err, nerr;
    logic [1:0]          retry, nretry;
    logic [CNT_W-1:0]    cap, ncap;
`endif

    assign done = cnt == '0;

    always_comb begin
        nstate = state;
        ncnt   = done ? cnt : cnt - PH_W'(1);
        nwin   = win;
        ndata  = data;
`ifdef RIPPLE_CTRL_DBLSAMPLE_EN
        nerr   = err;
        nretry = retry;
        ncap   = cap;
`endif
        if (bus.abort && state != IDLE && state != RESULT)
            nstate = IDLE;
        else
            case (state)
                IDLE: if (bus.start && !bus.abort) begin
                    nstate = CLEAR;
                    ncnt   = CLR_LD;
                    nwin   = bus.window;
`ifdef RIPPLE_CTRL_DBLSAMPLE_EN
                    nerr   = 1'b0;
                    nretry = 2'd0;
`endif
                end
                CLEAR: if (done) begin
                    nstate = win == '0 ? SETTLE : GATE;
                    ncnt   = win == '0 ? SET_LD : PH_W'(win - WINDOW_W'(1));
                end
                GATE: if (done) begin
                    nstate = SETTLE;
                    ncnt   = SET_LD;
                end
                SETTLE: if (done) begin
                    nstate = SAMPLE;
                    ncnt   = PH_W'(SAMP_LD);
                end
`ifdef RIPPLE_CTRL_DBLSAMPLE_EN
                // first cycle captures, second compares; after three retries the last capture is reported as an error
                SAMPLE: if (!done)
                    ncap = ctr_q;
                else if (ctr_q == cap || retry == 2'd3) begin
                    nstate = RESULT;
                    ndata  = ctr_q;
                    nerr   = ctr_q != cap;
                end else begin
                    nstate = SETTLE;
                    ncnt   = SET_LD;
                    nretry = retry + 2'd1;
                end
`else
                SAMPLE: begin
                    nstate = RESULT;
                    ndata  = ctr_q;
                end
`endif
                RESULT: if (bus.res_ready || bus.abort) nstate = IDLE;
                default: nstate = IDLE;
            endcase
    end

    // outputs are registered from the next state so gate and clear are glitch-free
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            win      <= '0;
            data     <= '0;
            ctr_clr  <= 1'b0;
            ctr_gate <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
`ifdef RIPPLE_CTRL_DBLSAMPLE_EN
            err      <= 1'b0;
            retry    <= 2'd0;
            cap      <= '0;
`endif
        end else begin
            state    <= nstate;
            cnt      <= ncnt;
            win      <= nwin;
            data     <= ndata;
            ctr_clr  <= nstate == CLEAR;
            ctr_gate <= nstate == GATE;
            busy_q   <= nstate != IDLE;
            valid_q  <= nstate == RESULT;
`ifdef RIPPLE_CTRL_DBLSAMPLE_EN
            err      <= nerr;
            retry    <= nretry;
            cap      <= ncap;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.res_valid = valid_q;
    assign bus.res_data  = data;
`ifdef RIPPLE_CTRL_DBLSAMPLE_EN
    assign bus.res_err   = err;
`else
    assign bus.res_err   = 1'b0;
`endif
endmodule

// File: tb/tb_ripple_counter_ctrl.sv
// tb_ripple_counter_ctrl: vector table plus corner-case sequences against an ideal ripple counter model
module tb_ripple_counter_ctrl;
`ifdef RIPPLE_CTRL_DBLSAMPLE_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    typedef struct {
        logic [64:0] data;
        logic        err;
        int          lat;
    } exp_t;
    typedef struct {
        logic [15:0] w;
        logic [64:0] data;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ctr_clr, ctr_gate;
    logic [64:0] ctr_q;
    logic [64:0] cnt_m = '0;
    logic [64:0] ovr = '0;
    logic        ovr_en = 1'b0, tog_en = 1'b0, tog = 1'b0;
    int          xfers = 0, gate_hi = 0;
    int          vectors = 0, miscompares = 0;
    exp_t        sb[$];
    vec_t        tbl[5];

    ripple_counter_ctrl_if #(.CNT_W(65), .WINDOW_W(16)) bus ();

    ripple_counter_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .ctr_q    (ctr_q),
        .ctr_clr  (ctr_clr),
        .ctr_gate (ctr_gate)
    );

    always #5 clk = ~clk;

    // ideal counter clocked by clk while gated; the counter reset is only ever ctr_clr
    always @(posedge clk) begin
        cnt_m   <= ctr_clr ? '0 : ctr_gate ? cnt_m + 65'd1 : cnt_m;
        tog     <= ~tog;
        gate_hi <= gate_hi + (ctr_gate ? 1 : 0);
        xfers   <= xfers + (bus.res_valid && bus.res_ready ? 1 : 0);
    end
    assign ctr_q = ovr_en ? ovr : cnt_m ^ {64'b0, tog & tog_en};

    function automatic void chk(string n, logic [64:0] act, logic [64:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endfunction

    task automatic launch(input logic [15:0] w);
        bus.start  = 1'b1;
        bus.window = w;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.window = 16'($urandom);
    endtask

    task automatic wait_valid(inout int lat);
        while (!bus.res_valid && lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run(input logic [15:0] w, input logic [64:0] d, input int l, input bit hs);
        exp_t e;
        int   lat;
        sb.push_back('{data: d, err: 1'b0, lat: l});
        launch(w);
        chk("clr_on", 65'(ctr_clr), 65'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("clr_off", 65'(ctr_clr), 65'd0);
        chk("gate_open", 65'(ctr_gate), 65'(w != 16'd0));
        lat = 2;
        wait_valid(lat);
        e = sb.pop_front();
        chk("latency", 65'(lat), 65'(e.lat));
        chk("res_data", bus.res_data, e.data);
        chk("res_err", 65'(bus.res_err), 65'(e.err));
        if (hs) begin
            bus.res_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.res_ready = 1'b0;
            chk("valid_drop", 65'(bus.res_valid), 65'd0);
            chk("idle_after", 65'(bus.busy), 65'd0);
        end
    endtask

    initial begin
        int g0, x0, lat;
        bit seen;
        tbl[0] = '{16'd10, 65'd10, 17 + EXTRA};
        tbl[1] = '{16'd0,  65'd0,  7 + EXTRA};
        tbl[2] = '{16'd1,  65'd1,  8 + EXTRA};
        tbl[3] = '{16'd3,  65'd3,  10 + EXTRA};
        tbl[4] = '{16'd37, 65'd37, 44 + EXTRA};
        bus.start = 1'b0; bus.abort = 1'b0; bus.window = '0; bus.res_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_clr", 65'(ctr_clr), 65'd0);
        chk("rst_gate", 65'(ctr_gate), 65'd0);
        chk("rst_busy", 65'(bus.busy), 65'd0);
        chk("rst_valid", 65'(bus.res_valid), 65'd0);
        chk("rst_data", bus.res_data, 65'd0);
        chk("rst_err", 65'(bus.res_err), 65'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) run(tbl[i].w, tbl[i].data, tbl[i].lat, 1'b1);

        // result held while host stalls; start pulses are ignored and not queued
        run(16'd0, 65'd0, 7 + EXTRA, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.start  = ~bus.start;
            bus.window = 16'd5;
            @(posedge clk);
            #1;
            chk("hold_valid", 65'(bus.res_valid), 65'd1);
            chk("hold_data", bus.res_data, 65'd0);
            chk("hold_busy", 65'(bus.busy), 65'd1);
        end
        bus.start = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("no_queued_start", 65'(bus.busy), 65'd0);

        // abort on the 4th gate cycle
        g0 = gate_hi;
        launch(16'd20);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        chk("abort_gate", 65'(ctr_gate), 65'd0);
        chk("abort_busy", 65'(bus.busy), 65'd0);
        chk("abort_gate_cycles", 65'(gate_hi - g0), 65'd4);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            seen |= bus.res_valid;
        end
        chk("abort_no_result", 65'(seen), 65'd0);
        run(16'd20, 65'd20, 27 + EXTRA, 1'b1);

        // abort with ready in RESULT completes the transfer; abort alone discards
        run(16'd3, 65'd3, 10 + EXTRA, 1'b0);
        x0 = xfers;
        bus.abort = 1'b1; bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0; bus.res_ready = 1'b0;
        chk("abort_ready_xfer", 65'(xfers - x0), 65'd1);
        chk("abort_ready_valid", 65'(bus.res_valid), 65'd0);
        chk("abort_ready_busy", 65'(bus.busy), 65'd0);
        run(16'd5, 65'd5, 12 + EXTRA, 1'b0);
        x0 = xfers;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        chk("abort_only_xfer", 65'(xfers - x0), 65'd0);
        chk("abort_only_valid", 65'(bus.res_valid), 65'd0);

        // abort beats start in IDLE
        bus.start = 1'b1; bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("start_abort_busy", 65'(bus.busy), 65'd0);
        chk("start_abort_clr", 65'(ctr_clr), 65'd0);

        // asynchronous reset in the middle of a long gate
        launch(16'd100);
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        chk("pre_reset_gate", 65'(ctr_gate), 65'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_gate", 65'(ctr_gate), 65'd0);
        chk("mid_rst_busy", 65'(bus.busy), 65'd0);
        chk("mid_rst_valid", 65'(bus.res_valid), 65'd0);
        chk("mid_rst_data", bus.res_data, 65'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_busy", 65'(bus.busy), 65'd0);
        run(16'd6, 65'd6, 13 + EXTRA, 1'b1);

`ifdef RIPPLE_CTRL_DBLSAMPLE_EN
        tog_en = 1'b1;
        launch(16'd0);
        lat = 0;
        wait_valid(lat);
        chk("dbl_retry_latency", 65'(lat), 65'(7 + 1 + 3 * 6));
        chk("dbl_retry_err", 65'(bus.res_err), 65'd1);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        tog_en = 1'b0;
        ovr_en = 1'b1;
        ovr = 65'h1_0000_0000_0000_0005;
        run(16'd0, 65'h1_0000_0000_0000_0005, 8, 1'b1);
        ovr_en = 1'b0;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
